// File: rtl/register_read_unit_if.sv
// Decode / write-back bundle for the register read unit.
// Master is the pipeline side that drives decode and write-back. Slave is the register read unit.
interface register_read_unit_if #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic              issue;
  logic [AW-1:0]     rd_addr;
  logic              rd_we;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] ans_wb;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              stall;
  logic [NREG-1:0]   pend_mask;

  modport master (
    output rs_addr, rt_addr, issue, rd_addr, rd_we, wb_en, wb_addr, ans_wb,
    input  rs_data, rt_data, stall, pend_mask
  );

  modport slave (
    input  rs_addr, rt_addr, issue, rd_addr, rd_we, wb_en, wb_addr, ans_wb,
    output rs_data, rt_data, stall, pend_mask
  );
endinterface

// File: rtl/register_read_unit.sv
// Register file with registered operand reads, write-back bypass and a
// pending-write scoreboard that raises a combinational hazard stall.
module register_read_unit #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic Clk,
  input  logic Rst,
  register_read_unit_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] reg_rd [NREG];       // current contents of each register
  logic [DATA_W-1:0] rs_data_reg, rt_data_reg;
  logic [DATA_W-1:0] rs_data_next, rt_data_next;
  logic [NREG-1:0]   pend_reg, pend_next;
  logic [NREG-1:0]   wb_hit;              // one-hot of this cycle's write-back index
  logic [NREG-1:0]   pend_eff;            // pending bits that survive this cycle's write-back
  logic              hz_rs, hz_rt, hz_waw;
  logic              stall_c;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign wb_hit[gi]   = bus.wb_en && (bus.wb_addr == AW'(gi));
      assign pend_eff[gi] = pend_reg[gi] && !wb_hit[gi];

      if (gi == 0) begin : g_zero
        // R0 is hard-wired to zero; no storage behind it.
        assign reg_rd[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] value_reg;
        // Write-back port for this register.
        always_ff @(posedge Clk) begin
          if (Rst) begin
            value_reg <= '0;
          end else if (wb_hit[gi]) begin
            value_reg <= bus.ans_wb;
          end
        end
        assign reg_rd[gi] = value_reg;
      end
    end
  endgenerate

  // Hazard detection: a source or destination still waiting on an
  // outstanding write holds decode. Index 0 is never pending.
  always_comb begin
    hz_rs   = (bus.rs_addr != '0) && pend_eff[bus.rs_addr];
    hz_rt   = (bus.rt_addr != '0) && pend_eff[bus.rt_addr];
    hz_waw  = bus.rd_we && (bus.rd_addr != '0) && pend_eff[bus.rd_addr];
    stall_c = bus.issue && (hz_rs || hz_rt || hz_waw);
    accept  = bus.issue && !stall_c;
  end

  // Operand selection with same-cycle write-back bypass; outputs hold unless issue is accepted.
  always_comb begin
    rs_data_next = rs_data_reg;
    rt_data_next = rt_data_reg;
    if (accept) begin
      if (bus.rs_addr == '0) begin
        rs_data_next = '0;
      end else if (wb_hit[bus.rs_addr]) begin
        rs_data_next = bus.ans_wb;
      end else begin
        rs_data_next = reg_rd[bus.rs_addr];
      end
      if (bus.rt_addr == '0) begin
        rt_data_next = '0;
      end else if (wb_hit[bus.rt_addr]) begin
        rt_data_next = bus.ans_wb;
      end else begin
        rt_data_next = reg_rd[bus.rt_addr];
      end
    end
  end

  // Scoreboard update: write-back clears first, so a same-index set wins.
  always_comb begin
    pend_next = pend_reg & ~wb_hit;
    if (accept && bus.rd_we && (bus.rd_addr != '0)) begin
      pend_next[bus.rd_addr] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Registered read outputs and scoreboard.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      pend_reg    <= '0;
    end else begin
      rs_data_reg <= rs_data_next;
      rt_data_reg <= rt_data_next;
      pend_reg    <= pend_next;
    end
  end

  assign bus.rs_data   = rs_data_reg;
  assign bus.rt_data   = rt_data_reg;
  assign bus.stall     = stall_c;
  assign bus.pend_mask = pend_reg;
endmodule

// File: doc/register_read_unit.md
REGISTER_READ_UNIT -- requirements
Module: register_read_unit

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register and write-back data width.
REQ-002 Parameter NREG, default 8, SHALL set the register count; address width AW = log2(NREG) = 3.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 rs_addr  input  AW  SHALL be the first source register index from decode.
REQ-006 rt_addr  input  AW  SHALL be the second source register index from decode.
REQ-007 issue  input  1  SHALL mean decode requests issue of the current instruction this cycle.
REQ-008 rd_addr  input  AW  SHALL be the destination register of the issuing instruction.
REQ-009 rd_we  input  1  SHALL mean the issuing instruction will write rd_addr.
REQ-010 wb_en  input  1  SHALL mean the write-back stage presents valid data this cycle.
REQ-011 wb_addr  input  AW  SHALL be the write-back destination index.
REQ-012 ans_wb  input  DATA_W  SHALL be the write-back data.
REQ-013 rs_data  output  DATA_W  SHALL be the registered read of rs_addr.
REQ-014 rt_data  output  DATA_W  SHALL be the registered read of rt_addr.
REQ-015 stall  output  1  SHALL be the combinational hazard stall to decode.
REQ-016 pend_mask  output  NREG  SHALL be the registered scoreboard of pending writes, one bit per register.

Function
REQ-017 Storage: the block SHALL hold NREG registers; R0 SHALL always read 0, and writes to R0 SHALL be ignored.
REQ-018 Write: when wb_en=1 and wb_addr!=0, reg[wb_addr] SHALL take ans_wb at the clock edge.
REQ-019 Read latency: rs_data/rt_data SHALL update one cycle after an accepted issue (issue=1, stall=0) and SHALL hold otherwise.
REQ-020 Bypass: if wb_en=1 and wb_addr equals a nonzero source address in the same cycle, the corresponding output SHALL capture ans_wb, not the old value.
REQ-021 Hazard: stall SHALL be 1 when issue=1 and any of the following holds:
  - pend_mask[rs_addr]=1 and not cleared by write-back this cycle;
  - pend_mask[rt_addr]=1 and not cleared by write-back this cycle;
  - rd_we=1 and pend_mask[rd_addr]=1 and not cleared this cycle (WAW).
REQ-022 Index 0 SHALL never cause a stall.
REQ-023 stall SHALL be 0 whenever issue=0.
REQ-024 Scoreboard set: an accepted issue with rd_we=1 and rd_addr!=0 SHALL set pend_mask[rd_addr].
REQ-025 Scoreboard clear: wb_en=1 SHALL clear pend_mask[wb_addr]. If set and clear hit the same index in one cycle, set SHALL win.
REQ-026 A write-back to a non-pending register SHALL update storage and leave pend_mask unchanged at that bit.
REQ-027 pend_mask[0] SHALL always be 0.

Reset
REQ-028 On Rst=1 at a clock edge:
  - all registers SHALL become 0;
  - rs_data and rt_data SHALL become 0;
  - pend_mask SHALL become 0.
REQ-029 During Rst, issue and wb_en SHALL be ignored, including a write-back in flight.
REQ-030 stall SHALL be 0 in the first cycle after reset.

Verification
REQ-031 Reset, then write R3=0x5A via wb, then issue rs=3 rt=0 -> next cycle rs_data=0x5A, rt_data=0x00.
REQ-032 Issue rd_we=1 rd=4, then issue rs=4 -> stall=1, held until wb_en wb_addr=4 ans_wb=0x21. In that wb cycle stall=0, and the next cycle rs_data=0x21 (bypass).
REQ-033 Same cycle: wb_en to R5 and accepted issue with rd=5 -> pend_mask[5]=1 afterwards (set wins).
REQ-034 wb_en wb_addr=0 ans_wb=0xFF, then read R0 -> rs_data=0x00; pend_mask=0x00.
REQ-035 Pending R2 (pend_mask=0x04), issue rd=2 rd_we=1 -> stall=1 (WAW). Assert Rst mid-stall -> pend_mask=0x00, stall=0 after reset.
REQ-036 Issue rs=6 rt=7 with no pending bits and no wb -> stall=0; outputs equal stored R6/R7 one cycle later; outputs hold while issue=0.
